// File: rtl/pipe_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and iteration count.
package pipe_muldiv_pkg;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // The upper op bit selects divide, the lower bit selects unsigned.
  function automatic logic md_is_div(md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the mul/div datapath.
// Multiply: acc = (acc << 1) + (bit_in ? mag : 0), multiplier bits MSB first.
// Divide:   acc = {remainder, quotient}; shift in the next dividend bit and
//           trial-subtract the divisor (restoring division).
module muldiv_step
  import pipe_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mag,
  input  logic               bit_in,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Compute either the add-shift or the trial-subtract-shift result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    acc_next = '0;
    partial  = {acc[2*WIDTH-1:WIDTH], bit_in};
    fits     = (partial >= {1'b0, mag});
    trial    = partial[WIDTH-1:0] - mag;
    if (is_div) begin
      if (fits) begin
        acc_next = {trial, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {acc[2*WIDTH-2:0], 1'b0} + (bit_in ? {{WIDTH{1'b0}}, mag} : '0);
    end
  end

endmodule

// File: rtl/pipe_intr_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Fixed 33-cycle start-to-ready latency; cancel flushes any operation in flight.
module pipe_intr_muldiv
  import pipe_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e           state_q, state_d;
  md_op_e              op_q;
  logic [MD_CNT_W-1:0] count_q;
  logic [2*WIDTH-1:0]  acc_q, acc_step;
  logic [WIDTH-1:0]    a_mag_q, b_mag_q;
  logic                sa_q, sb_q;
  logic                accept, last_iter;
  logic                op_signed, a_neg, b_neg;
  logic                step_bit;
  logic [WIDTH-1:0]    res_hi, res_lo;

  assign accept    = (state_q == IDLE) && start && !cancel;
  assign last_iter = (state_q == CALC) && (count_q == MD_CNT_W'(MD_ITERS - 1));
  assign op_signed = md_is_signed(md_op_e'(op));
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];

  // Multiplier bits (multiply) or dividend bits (divide) are consumed MSB first.
  assign step_bit = md_is_div(op_q) ? a_mag_q[~count_q] : b_mag_q[~count_q];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (md_is_div(op_q)),
    .acc      (acc_q),
    .mag      (md_is_div(op_q) ? b_mag_q : a_mag_q),
    .bit_in   (step_bit),
    .acc_next (acc_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; cancel returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel) state_d = IDLE;
  end

  assign busy  = (state_q != IDLE);
  assign ready = (state_q == DONE);

  // Operand capture at start, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      // NOTE: the operand and accumulator registers are reset too, so a reset mid-operation leaves no stale state.
      op_q    <= MD_MULT;
      count_q <= '0;
      acc_q   <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else if (accept) begin
      op_q    <= md_op_e'(op);
      count_q <= '0;
      acc_q   <= '0;
      a_mag_q <= a_neg ? -a : a;
      b_mag_q <= b_neg ? -b : b;
      sa_q    <= a_neg;
      sb_q    <= b_neg;
    end else if (state_q == CALC) begin
      acc_q   <= acc_step;
      count_q <= count_q + 1'b1;
    end
  end

  // Sign fix-up of the final accumulator; unsigned ops have both signs clear.
  always_comb begin
    res_hi = acc_step[2*WIDTH-1:WIDTH];
    res_lo = acc_step[WIDTH-1:0];
    if (md_is_div(op_q)) begin
      if (sa_q ^ sb_q) res_lo = -acc_step[WIDTH-1:0];
      if (sa_q)        res_hi = -acc_step[2*WIDTH-1:WIDTH];
    end else if (sa_q ^ sb_q) begin
      {res_hi, res_lo} = -acc_step;
    end
  end

  // HI/LO: MTHI/MTLO in IDLE, result on the last iteration unless cancelled.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == IDLE) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end else if (last_iter && !cancel) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

endmodule

// File: tb/tb_pipe_intr_muldiv.sv
// Self-checking bench for pipe_intr_muldiv: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_pipe_intr_muldiv;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] a, b, wdata;
  logic [1:0]  op;
  logic        start, cancel, hi_we, lo_we;
  logic        busy, ready;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  pipe_intr_muldiv #(.WIDTH(32)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .a      (a),
    .b      (b),
    .op     (op),
    .start  (start),
    .cancel (cancel),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .ready  (ready),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: {hi, lo} from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] q, r, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      2'd0: res = sx * sy;
      2'd1: res = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) begin
          res = {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
        end else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else        res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Wait for ready with a bounded budget; n = edges waited.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, busy, 1);
    wait_ready(n);
    check({tag, " latency"}, n, 32);
    check({tag, " hi"}, hi, exp[63:32]);
    check({tag, " lo"}, lo, exp[31:0]);
    tick();
    check({tag, " idle"}, {busy, ready}, 0);
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [31:0] hold_hi, hold_lo, x, y;
    logic [1:0]  o;

    clrn = 1'b0; a = '0; b = '0; op = '0; start = 0; cancel = 0;
    hi_we = 0; lo_we = 0; wdata = '0;
    tick(); tick();
    clrn = 1'b1;
    check("reset busy",  busy,  0);
    check("reset ready", ready, 0);
    check("reset hi",    hi,    0);
    check("reset lo",    lo,    0);

    // MTHI then MTLO in IDLE.
    hi_we = 1; wdata = 32'hAAAA_5555; tick(); hi_we = 0;
    check("mthi hi", hi, 32'hAAAA_5555);
    lo_we = 1; wdata = 32'h5555_AAAA; tick(); lo_we = 0;
    check("mtlo lo", lo, 32'h5555_AAAA);
    check("mtlo hi kept", hi, 32'hAAAA_5555);

    // Directed arithmetic cases.
    run_op("mult -3*7",   2'd0, 32'hFFFF_FFFD, 32'h7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu",       2'd1, 32'hFFFF_FFFD, 32'h7, 64'h0000_0006_FFFF_FFEB);
    run_op("div -7/2",    2'd2, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu 7/2",    2'd3, 32'h7,         32'h2, 64'h0000_0001_0000_0003);
    run_op("divu by 0",   2'd3, 32'h1234_5678, 32'h0, 64'h1234_5678_FFFF_FFFF);
    run_op("div ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("div -8/0",    2'd2, 32'hFFFF_FFF8, 32'h0, 64'hFFFF_FFF8_0000_0001);

    // MTHI during CALC is ignored.
    op = 2'd1; a = 32'h1_0000; b = 32'h1_0000; start = 1; tick(); start = 0;
    hold_hi = hi;
    repeat (5) tick();
    hi_we = 1; wdata = 32'hDEAD_BEEF; tick(); hi_we = 0;
    check("mthi in calc", hi, hold_hi);
    wait_ready(n);
    check("mthi calc hi", hi, 32'h1);
    check("mthi calc lo", lo, 32'h0);
    tick();

    // start together with MTHI/MTLO: both act, result lands later.
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1; hi_we = 1; lo_we = 1; wdata = 32'hCAFE_F00D;
    tick();
    start = 0; hi_we = 0; lo_we = 0;
    check("start+mt hi", hi, 32'hCAFE_F00D);
    check("start+mt lo", lo, 32'hCAFE_F00D);
    wait_ready(n);
    check("start+mt latency", n, 32);
    check("start+mt res", {hi, lo}, {32'd2, 32'd14});
    tick();

    // Cancel at iteration 10 of a DIV.
    hold_hi = hi; hold_lo = lo;
    op = 2'd2; a = 32'd1000; b = 32'd3; start = 1; tick(); start = 0;
    repeat (10) tick();
    cancel = 1; tick(); cancel = 0;
    check("cancel busy", busy, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (ready) seen = 1;
    end
    check("cancel no ready", seen, 0);
    check("cancel hi/lo", {hi, lo}, {hold_hi, hold_lo});

    // start + cancel in the same cycle stays IDLE.
    op = 2'd1; a = 32'd5; b = 32'd5; start = 1; cancel = 1; tick(); start = 0; cancel = 0;
    check("start+cancel busy", busy, 0);
    tick();
    check("start+cancel ready", ready, 0);

    // Cancel during DONE: result kept, unit returns to IDLE.
    op = 2'd0; a = 32'hFFFF_FF00; b = 32'd3; start = 1; tick(); start = 0;
    wait_ready(n);
    check("cancel done ready", ready, 1);
    cancel = 1; tick(); cancel = 0;
    check("cancel done busy", busy, 0);
    check("cancel done res", {hi, lo}, model(2'd0, 32'hFFFF_FF00, 32'd3));

    // Reset mid-CALC.
    op = 2'd0; a = 32'd12345; b = 32'd678; start = 1; tick(); start = 0;
    repeat (5) tick();
    clrn = 0; tick(); clrn = 1;
    check("midreset outs", {busy, ready, hi, lo}, 0);
    run_op("after reset", 2'd0, 32'd12345, 32'hFFFF_FFFE, model(2'd0, 32'd12345, 32'hFFFF_FFFE));

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       x = 32'h8000_0000;
        1:       x = 32'($urandom_range(0, 255));
        default: x = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, o), o, x, y, model(o, x, y));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
